// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package package_project_typedefs;

    // Controller FSM states; encoding is exposed on the ctrl_state debug port.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } PipeCtrlState;

    // Flush cycles applied per taken branch, counting the branch cycle itself.
    localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

    // Width of the remaining-flush counter; covers the legal 1..7 range.
    localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller with performance counters.
// Control outputs are combinational from state and inputs; state is registered.
module pipeline_control
    import package_project_typedefs::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             insert_nop,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             perf_clear,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       ctrl_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam PipeCtrlState           BRANCH_NEXT = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

    PipeCtrlState           state;
    PipeCtrlState           state_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_next;
    logic                   branch_accept;

    // Output decode and next-state logic; priority mem_busy > branch_taken > insert_nop.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        pipe_freeze    = 1'b0;
        branch_accept  = 1'b0;
        state_next     = state;
        flush_cnt_next = flush_cnt;

        if (mem_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            pipe_freeze    = 1'b1;
        end else if (branch_taken) begin
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            branch_accept  = 1'b1;
            flush_cnt_next = FLUSH_LOAD;
            state_next     = BRANCH_NEXT;
        end else begin
            case (state)
                RUN: begin
                    if (insert_nop) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                        state_next     = LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    state_next = RUN;
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    // The counter holds the FLUSH-state cycles still owed, this one included.
                    if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                        flush_cnt_next = '0;
                        state_next     = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state_next     = RUN;
                    flush_cnt_next = '0;
                end
            endcase
        end
    end

    // State and flush counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    assign ctrl_state = state;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clear),
        .inc   (~pc_write_en),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clear),
        .inc   (branch_accept),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control.
module tb_pipeline_control;
    import package_project_typedefs::*;

    logic        clk = 1'b0;
    logic        reset, insert_nop, branch_taken, mem_busy, perf_clear;
    logic        pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, pipe_freeze;
    logic [31:0] stall_cycles, flush_events;
    logic [1:0]  ctrl_state;
    logic [4:0]  ctrl;

    logic        mem_busy4, zero;
    logic        pc_we4, ifid_we4, bubble4, flush4, freeze4;
    logic [3:0]  stall4, fe4;
    logic [1:0]  state4;
    logic [4:0]  ctrl4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctrl  = {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, pipe_freeze};
    assign ctrl4 = {pc_we4, ifid_we4, bubble4, flush4, freeze4};

    pipeline_control dut (
        .clk            (clk),
        .reset          (reset),
        .insert_nop     (insert_nop),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .perf_clear     (perf_clear),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .pipe_freeze    (pipe_freeze),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events),
        .ctrl_state     (ctrl_state)
    );

    pipeline_control #(
        .CNT_W(4)
    ) dut4 (
        .clk            (clk),
        .reset          (reset),
        .insert_nop     (zero),
        .branch_taken   (zero),
        .mem_busy       (mem_busy4),
        .perf_clear     (zero),
        .pc_write_en    (pc_we4),
        .if_id_write_en (ifid_we4),
        .id_ex_bubble   (bubble4),
        .if_id_flush    (flush4),
        .pipe_freeze    (freeze4),
        .stall_cycles   (stall4),
        .flush_events   (fe4),
        .ctrl_state     (state4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctrl bit order: {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, pipe_freeze}
    initial begin
        zero = 1'b0; mem_busy4 = 1'b0;
        reset = 1'b1; insert_nop = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; perf_clear = 1'b0;
        tick(); tick();
        chk("rst_state", ctrl_state, RUN);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_fe", flush_events, 0);
        chk("rst_ctrl", ctrl, 5'b11000);
        reset = 1'b0;

        // Load-use stall then LOAD_STALL ignoring insert_nop
        insert_nop = 1'b1; #1;
        chk("nop_ctrl", ctrl, 5'b00100);
        tick();
        chk("ls_state", ctrl_state, LOAD_STALL);
        chk("ls_ctrl_ignore", ctrl, 5'b11000);
        chk("ls_stall", stall_cycles, 1);
        insert_nop = 1'b0;
        tick();
        chk("ls_back_run", ctrl_state, RUN);
        chk("ls_stall_hold", stall_cycles, 1);

        // Taken branch, two flush cycles
        branch_taken = 1'b1; #1;
        chk("br_ctrl0", ctrl, 5'b11110);
        tick();
        branch_taken = 1'b0; #1;
        chk("br_state_flush", ctrl_state, FLUSH);
        chk("br_ctrl1", ctrl, 5'b11110);
        chk("br_fe", flush_events, 1);
        tick();
        chk("br_back_run", ctrl_state, RUN);
        chk("br_ctrl_idle", ctrl, 5'b11000);

        // Branch and insert_nop together: branch wins, no stall
        branch_taken = 1'b1; insert_nop = 1'b1; #1;
        chk("bn_ctrl", ctrl, 5'b11110);
        tick();
        branch_taken = 1'b0; insert_nop = 1'b0; #1;
        chk("bn_stall", stall_cycles, 1);
        chk("bn_fe", flush_events, 2);
        tick();
        chk("bn_run", ctrl_state, RUN);

        // Freeze for three cycles in FLUSH; first busy cycle also carries branch+nop
        branch_taken = 1'b1;
        tick();
        insert_nop = 1'b1; mem_busy = 1'b1; #1;
        chk("fz_ctrl_prio", ctrl, 5'b00001);
        tick();
        branch_taken = 1'b0; insert_nop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fz_ctrl", ctrl, 5'b00001);
            chk("fz_state", ctrl_state, FLUSH);
            tick();
        end
        mem_busy = 1'b0; #1;
        chk("fz_fe_hold", flush_events, 3);
        chk("fz_stall", stall_cycles, 4);
        chk("fz_resume_state", ctrl_state, FLUSH);
        chk("fz_resume_ctrl", ctrl, 5'b11110);
        tick();
        chk("fz_done", ctrl_state, RUN);

        // Reset mid-FLUSH
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("rf_state", ctrl_state, RUN);
        chk("rf_stall", stall_cycles, 0);
        chk("rf_fe", flush_events, 0);
        tick();
        chk("rf_stay_run", ctrl_state, RUN);

        // perf_clear overrides pending increments, FSM unaffected
        insert_nop = 1'b1;
        tick();
        insert_nop = 1'b0;
        tick();
        chk("pc_pre", stall_cycles, 1);
        insert_nop = 1'b1; perf_clear = 1'b1;
        tick();
        insert_nop = 1'b0; perf_clear = 1'b0; #1;
        chk("pc_stall", stall_cycles, 0);
        chk("pc_fsm", ctrl_state, LOAD_STALL);
        tick();
        branch_taken = 1'b1;
        tick();
        chk("pc_fe_pre", flush_events, 1);
        perf_clear = 1'b1;
        tick();
        branch_taken = 1'b0; perf_clear = 1'b0; #1;
        chk("pc_fe", flush_events, 0);
        chk("pc_fe_fsm", ctrl_state, FLUSH);
        tick();

        // 4-bit counter saturation under long freeze
        mem_busy4 = 1'b1; #1;
        chk("sat_ctrl", ctrl4, 5'b00001);
        repeat (14) tick();
        chk("sat_14", stall4, 14);
        repeat (6) tick();
        chk("sat_hold", stall4, 15);
        chk("sat_state", state4, RUN);
        chk("sat_fe", fe4, 0);
        mem_busy4 = 1'b0;
        tick();
        chk("sat_after", stall4, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
